// File: rtl/rr_arbiter16_pkg.sv
// rr_arbiter16_pkg -- shared definitions for the round-robin arbiter slice.
//   state_t   : FSM encoding (IDLE = 1'b0, GRANT = 1'b1)
//   N_DEFAULT : default number of requesters
//   PTR_W     : round-robin pointer width for N_DEFAULT requesters
package rr_arbiter16_pkg;

  localparam int N_DEFAULT = 16;
  localparam int PTR_W     = $clog2(N_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter16_pick.sv
// rr_pick -- combinational round-robin selector.
// Ports:
//   r      [N-1:0]  effective request vector
//   ptr    [PW-1:0] search start index (highest priority this round)
//   onehot [N-1:0]  first set bit of r at or above ptr, wrapping; zero if r == 0
module rr_pick
  import rr_arbiter16_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  r,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot
);

  logic          found;
  logic [PW-1:0] idx;

  // N is a power of two, so the PW-bit sum wraps from N-1 back to 0 for free.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!found && r[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16 -- round-robin arbiter with registered one-hot grant and
// valid/ready handshake. One bubble cycle separates consecutive grants.
// Optional macro RR_ARBITER16_MASK_EN adds a request mask register
// (reset all-ones) loaded from mask_in when mask_we is high.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   mask_in    [N-1:0] mask write data     (RR_ARBITER16_MASK_EN only)
//   mask_we    mask write enable            (RR_ARBITER16_MASK_EN only)
//   req        [N-1:0] level request lines
//   gnt        [N-1:0] registered one-hot grant
//   gnt_valid  gnt holds a valid grant
//   gnt_ready  downstream accepts the current grant
//   busy       high while in GRANT
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef RR_ARBITER16_MASK_EN
  input  logic [N-1:0] mask_in,
  input  logic         mask_we,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  input  logic         gnt_ready,
  output logic         busy
);

  localparam int PW = $clog2(N);

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [N-1:0]  r;
  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;

`ifdef RR_ARBITER16_MASK_EN
  logic [N-1:0] mask;

  // Registered mask: a write affects arbitration from the following cycle,
  // and never touches a grant already being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask <= '1;
    else if (mask_we) mask <= mask_in;
  end

  assign r = req & mask;
`else
  assign r = req;
`endif

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .r      (r),
    .ptr    (ptr),
    .onehot (pick)
  );

  // Index of the picked requester, stored with the grant so the pointer
  // update on handshake does not need to re-encode gnt.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (r != '0) state_nxt = GRANT;
      GRANT:   if (gnt_valid && gnt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == GRANT);
  end

  // Grant and pointer registers; gnt_ready is only acted on in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r != '0) begin
            gnt       <= pick;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (gnt_valid && gnt_ready) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + PW'(1);
          end
        end
        default: begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
module tb_rr_arbiter16;
  import rr_arbiter16_pkg::*;

  localparam int N = N_DEFAULT;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         gnt_ready;
  logic         busy;
`ifdef RR_ARBITER16_MASK_EN
  logic [N-1:0] mask_in;
  logic         mask_we;
`endif

  int errors = 0;
  int checks = 0;

  rr_arbiter16 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RR_ARBITER16_MASK_EN
    .mask_in   (mask_in),
    .mask_we   (mask_we),
`endif
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 16-to-4 encoder model.
  function automatic logic [3:0] enc16(input logic [N-1:0] v);
    logic [3:0] y;
    y = '0;
    for (int i = 0; i < N; i++) if (v[i]) y = 4'(i);
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
`ifdef RR_ARBITER16_MASK_EN
    mask_in   = '0;
    mask_we   = 1'b0;
`endif
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL reset_gnt got=%h exp=%h", gnt, 16'h0000); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dut.ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_single();
    req = 16'h0010; gnt_ready = 1'b1;
    tick();
    checks++; if (gnt !== 16'h0010) begin errors++; $display("FAIL single_gnt got=%h exp=0010", gnt); end
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", gnt_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (enc16(gnt) !== 4'd4) begin errors++; $display("FAIL single_enc got=%0d exp=4", enc16(gnt)); end
    req = '0;
    tick();
    checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL single_hs_gnt got=%h exp=0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL single_hs_valid got=%b exp=0", gnt_valid); end
    checks++; if (dut.ptr !== 4'd5) begin errors++; $display("FAIL single_ptr got=%0d exp=5", dut.ptr); end
  endtask

  task automatic test_idle_ready();
    req = '0; gnt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL idle_ready got gnt=%h v=%b b=%b exp 0/0/0", gnt, gnt_valid, busy); end
      checks++; if (dut.ptr !== 4'd5) begin errors++; $display("FAIL idle_ptr got=%0d exp=5", dut.ptr); end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp;
    do_reset();
    req = 16'hFFFF; gnt_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp = '0;
      exp[k % 16] = 1'b1;
      tick();
      checks++; if (gnt !== exp || gnt_valid !== 1'b1)
        begin errors++; $display("FAIL fair_grant%0d got=%h v=%b exp=%h v=1", k, gnt, gnt_valid, exp); end
      tick();
      checks++; if (gnt !== 16'h0000 || gnt_valid !== 1'b0)
        begin errors++; $display("FAIL fair_bubble%0d got=%h v=%b exp=0000 v=0", k, gnt, gnt_valid); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 16'h0003; gnt_ready = 1'b0;
    tick();
    checks++; if (gnt !== 16'h0001 || gnt_valid !== 1'b1)
      begin errors++; $display("FAIL bp_first got=%h v=%b exp=0001 v=1", gnt, gnt_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (gnt !== 16'h0001 || gnt_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d got=%h v=%b exp=0001 v=1", k, gnt, gnt_valid); end
    end
    gnt_ready = 1'b1;
    tick();
    checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL bp_hs got=%h exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 16'h0002 || gnt_valid !== 1'b1)
      begin errors++; $display("FAIL bp_next got=%h v=%b exp=0002 v=1", gnt, gnt_valid); end
    req = '0;
    tick();
  endtask

  task automatic test_wrap_retract();
    do_reset();
    req = 16'h4000; gnt_ready = 1'b1;
    tick();
    req = '0;
    tick();
    checks++; if (dut.ptr !== 4'd15) begin errors++; $display("FAIL wrap_ptr15 got=%0d exp=15", dut.ptr); end
    req = 16'h8001; gnt_ready = 1'b0;
    tick();
    checks++; if (gnt !== 16'h8000) begin errors++; $display("FAIL wrap_gnt got=%h exp=8000", gnt); end
    req = 16'h0001;
    tick();
    checks++; if (gnt !== 16'h8000 || gnt_valid !== 1'b1)
      begin errors++; $display("FAIL retract_hold got=%h v=%b exp=8000 v=1", gnt, gnt_valid); end
    gnt_ready = 1'b1;
    tick();
    checks++; if (dut.ptr !== 4'd0) begin errors++; $display("FAIL wrap_ptr0 got=%0d exp=0", dut.ptr); end
    tick();
    checks++; if (gnt !== 16'h0001) begin errors++; $display("FAIL wrap_next got=%h exp=0001", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 16'h0100; gnt_ready = 1'b1;
    tick();
    tick();
    gnt_ready = 1'b0;
    tick();
    checks++; if (gnt !== 16'h0100 || dut.ptr !== 4'd9)
      begin errors++; $display("FAIL midrst_pre got=%h ptr=%0d exp=0100 ptr=9", gnt, dut.ptr); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL midrst_gnt got=%h exp=0000", gnt); end
    checks++; if (gnt_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_ctl got v=%b b=%b exp 0/0", gnt_valid, busy); end
    checks++; if (dut.ptr !== 4'd0) begin errors++; $display("FAIL midrst_ptr got=%0d exp=0", dut.ptr); end
    req = '0;
    tick();
    rst_n = 1'b1;
  endtask

`ifdef RR_ARBITER16_MASK_EN
  task automatic test_mask();
    do_reset();
    mask_in = 16'hFFFE; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    req = 16'h0003; gnt_ready = 1'b1;
    tick();
    checks++; if (gnt !== 16'h0002) begin errors++; $display("FAIL mask_first got=%h exp=0002", gnt); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (gnt[0] !== 1'b0) begin errors++; $display("FAIL mask_bit0_%0d got=%h exp bit0=0", k, gnt); end
    end
    req = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_idle_ready();
    test_fairness();
    test_backpressure();
    test_wrap_retract();
    test_reset_mid_grant();
`ifdef RR_ARBITER16_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL provide parameter: N, 16, number of requesters (2..16, power of two).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: req  input  N  level request lines, bit i = requester i.
REQ-005 SHALL provide port: gnt  output  N  registered one-hot grant vector; drives the downstream 16-to-4 encoder d input.
REQ-006 SHALL provide port: gnt_valid  output  1  gnt holds a valid grant.
REQ-007 SHALL provide port: gnt_ready  input  1  downstream accepts the current grant.
REQ-008 SHALL provide port: busy  output  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement a two-state FSM, IDLE and GRANT, with a registered round-robin pointer ptr of log2(N) bits.
REQ-010 In IDLE with effective request vector r != 0, SHALL select the first set bit of r searching upward from ptr, wrapping from N-1 to 0, then register the selection into gnt, set gnt_valid=1 and enter GRANT.
REQ-011 The latency from req sampled at edge k to gnt_valid=1 SHALL be exactly one cycle, with gnt_valid visible after edge k.
REQ-012 In IDLE with r == 0, SHALL keep gnt=0, gnt_valid=0 and ptr unchanged.
REQ-013 In GRANT, SHALL hold gnt and gnt_valid stable until gnt_valid & gnt_ready at a rising edge.
REQ-014 A granted requester dropping req during GRANT SHALL NOT retract the grant.
REQ-015 On handshake, SHALL set ptr to (granted index + 1) mod N, clear gnt to 0, clear gnt_valid and return to IDLE, giving one bubble cycle between grants.
REQ-016 gnt SHALL always be zero or exactly one-hot; gnt_valid=1 SHALL imply that gnt is one-hot.
REQ-017 A gnt_ready seen while in IDLE SHALL be ignored.
REQ-018 busy SHALL equal (state == GRANT).
REQ-019 The pointer wrap SHALL be handled as follows: grant to index N-1 sets ptr=0.

Reset
REQ-020 Asserting rst_n low SHALL immediately set state=IDLE, gnt=0, gnt_valid=0, busy=0 and ptr=0, including mid-GRANT.
REQ-021 After rst_n is deasserted, SHALL make the first arbitration occur on the first rising edge with r != 0.

Configuration
REQ-022 With macro RR_ARBITER16_MASK_EN defined, SHALL add ports mask_in (input, N) and mask_we (input, 1), plus an N-bit mask register with reset value all-ones, loaded from mask_in on any edge with mask_we=1; r = req & mask.
REQ-023 A mask write SHALL take effect for arbitration one cycle after the write and SHALL NOT alter a grant already held in GRANT.
REQ-024 Without RR_ARBITER16_MASK_EN, SHALL omit mask_in, mask_we and the mask register, and set r = req.

Structure
REQ-025 SHALL place the FSM state encodings (IDLE=1'b0, GRANT=1'b1), the default N and the pointer width in a shared package/header used by the arbiter and the bench.
REQ-026 SHALL implement round-robin selection as one combinational sub-module, rr_pick, with inputs r and ptr and a one-hot output; the top module holds all registers.

Verification
REQ-027 Single request: req=16'h0010 with gnt_ready=1 -> gnt=16'h0010 and gnt_valid=1 one cycle later; encoder y=4'd4; ptr=5 after the handshake.
REQ-028 Round-robin fairness: req=16'hFFFF held, gnt_ready=1 -> grants 0,1,2,...,15,0 on successive grant cycles, one bubble apart.
REQ-029 Backpressure: req=16'h0003, gnt_ready=0 for 5 cycles -> gnt=16'h0001 stable throughout; then ready=1 -> next grant 16'h0002.
REQ-030 Wrap and retraction: ptr=15, req=16'h8001 -> gnt=16'h8000; drop req[15] while ready=0 -> grant held; after the handshake -> gnt=16'h0001.
REQ-031 Reset mid-GRANT: rst_n low while gnt=16'h0100 -> gnt=0, gnt_valid=0, ptr=0 immediately, without waiting for a clock edge.
REQ-032 With RR_ARBITER16_MASK_EN: write mask 16'hFFFE, then req=16'h0003 -> gnt=16'h0002, and bit 0 is never granted.
